hdb3_decoder: RTL and testbench

- Receive-side counterpart of the HDB3 line encoder. Samples the dual-rail bipolar line (bp/bn), one symbol per clk.
- Detects bipolar violations and removes 000V / B00V substitutions, restoring the original NRZ bit stream with fixed latency.
- Flags line-code errors.
- Sits after the line interface, feeding the bit-level receive logic.

---
 rtl/hdb3_pkg.sv | 16 +
 rtl/hdb3_viol_detect.sv | 74 +++++++
 rtl/hdb3_decoder.sv | 110 +++++++++++
 tb/tb_hdb3_decoder.sv | 109 ++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// Shared HDB3 line-code constants, used by both the encoder and the decoder.
package hdb3_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_NEG  = 2'b01;
  localparam logic [1:0] SYM_POS  = 2'b10;
  localparam logic [1:0] SYM_ILL  = 2'b11;

  localparam int HDB3_DLY      = 4;
  localparam int HDB3_MAX_ZERO = 3;

  function automatic logic sym_is_mark(input logic [1:0] sym);
    return (sym == SYM_POS) || (sym == SYM_NEG);
  endfunction

endpackage

// File: rtl/hdb3_viol_detect.sv
// Symbol classifier and violation tracker: last mark polarity, first-mark flag,
// raw zero-run length, and the registered line-error strobes.
module hdb3_viol_detect
  import hdb3_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bp,
  input  logic bn,
  input  logic sh0,
  input  logic sh1,
  output logic is_mark,
  output logic is_v,
  output logic legal_v,
  output logic code_err,
  output logic viol_err,
  output logic zero_err
);

  logic [1:0] sym;
  logic       mark_pol;
  logic       last_pol_q, last_pol_d;
  logic       first_mark_q, first_mark_d;
  logic [2:0] zero_run_q, zero_run_d;
  logic       code_err_q, code_err_d;
  logic       viol_err_q, viol_err_d;
  logic       zero_err_q, zero_err_d;

  assign sym      = {bp, bn};
  assign is_mark  = sym_is_mark(sym);
  assign mark_pol = (sym == SYM_POS);
  assign is_v     = is_mark && !first_mark_q && (mark_pol == last_pol_q);
  assign legal_v  = is_v && !sh0 && !sh1;

  always_comb begin
    last_pol_d   = last_pol_q;
    first_mark_d = first_mark_q;
    zero_run_d   = zero_run_q;
    if (is_mark) begin
      last_pol_d   = mark_pol;
      first_mark_d = 1'b0;
      zero_run_d   = '0;
    end else if (zero_run_q != 3'(HDB3_MAX_ZERO + 1)) begin
      zero_run_d = zero_run_q + 3'd1;
    end
    code_err_d = (sym == SYM_ILL);
    viol_err_d = is_v && !legal_v;
    // Fires only on the sample that takes the run from 3 to 4.
    zero_err_d = !is_mark && (zero_run_q == 3'(HDB3_MAX_ZERO));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_pol_q   <= 1'b0;
      first_mark_q <= 1'b1;
      zero_run_q   <= '0;
      code_err_q   <= 1'b0;
      viol_err_q   <= 1'b0;
      zero_err_q   <= 1'b0;
    end else begin
      last_pol_q   <= last_pol_d;
      first_mark_q <= first_mark_d;
      zero_run_q   <= zero_run_d;
      code_err_q   <= code_err_d;
      viol_err_q   <= viol_err_d;
      zero_err_q   <= zero_err_d;
    end
  end

  assign code_err = code_err_q;
  assign viol_err = viol_err_q;
  assign zero_err = zero_err_q;

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: strips 000V/B00V substitutions with a 4-deep delay line.
// Define HDB3_ERR_CNT_EN to add the saturating err_cnt output.
module hdb3_decoder
  import hdb3_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bp,
  input  logic bn,
  output logic data_out,
  output logic data_valid,
  output logic code_err,
  output logic viol_err,
  output logic zero_err
`ifdef HDB3_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic                is_mark;
  logic                is_v;
  logic                legal_v;
  logic [HDB3_DLY-1:0] sh_q, sh_d;
  logic [2:0]          fill_q, fill_d;
  logic                data_out_q;
  logic                data_valid_q, data_valid_d;

  hdb3_viol_detect u_viol (
    .clk      (clk),
    .rst_n    (rst_n),
    .bp       (bp),
    .bn       (bn),
    .sh0      (sh_q[0]),
    .sh1      (sh_q[1]),
    .is_mark  (is_mark),
    .is_v     (is_v),
    .legal_v  (legal_v),
    .code_err (code_err),
    .viol_err (viol_err),
    .zero_err (zero_err)
  );

  // A legal V enters the line as 0; an illegal one is kept as a mark.
  assign sh_d[0] = is_mark && !legal_v;

  generate
    for (genvar gi = 1; gi < HDB3_DLY; gi++) begin : g_shift
      if (gi == HDB3_DLY - 1) begin : g_last
        // B pulse of a B00V pattern is cleared as it moves into the last stage.
        assign sh_d[gi] = sh_q[gi-1] && !(legal_v && is_v);
      end else begin : g_mid
        assign sh_d[gi] = sh_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    fill_d       = fill_q;
    data_valid_d = data_valid_q;
    if (fill_q != 3'(HDB3_DLY)) begin
      fill_d = fill_q + 3'd1;
    end else begin
      data_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q         <= '0;
      fill_q       <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      sh_q         <= sh_d;
      fill_q       <= fill_d;
      data_out_q   <= sh_q[HDB3_DLY-1];
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

`ifdef HDB3_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]           err_inc;
  logic [ERR_CNT_W:0]   err_sum;

  assign err_inc = {1'b0, code_err} + {1'b0, viol_err} + {1'b0, zero_err};
  assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(err_inc);

  always_comb begin
    err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdb3_decoder.sv
// Directed-vector bench for hdb3_decoder; symbol strings use + - 0 X (X = bp=bn=1).
module tb_hdb3_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic bp    = 1'b0;
  logic bn    = 1'b0;
  logic data_out, data_valid, code_err, viol_err, zero_err;
`ifdef HDB3_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  hdb3_decoder #(.ERR_CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bp         (bp),
    .bn         (bn),
    .data_out   (data_out),
    .data_valid (data_valid),
    .code_err   (code_err),
    .viol_err   (viol_err),
    .zero_err   (zero_err)
`ifdef HDB3_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    bp    = 1'b0;
    bn    = 1'b0;
    @(posedge clk);
    #1;
    check({name, ".rst_outs"}, {27'd0, data_out, data_valid, code_err, viol_err, zero_err}, 32'd0);
`ifdef HDB3_ERR_CNT_EN
    check({name, ".rst_cnt"}, {16'd0, err_cnt}, 32'd0);
`endif
  endtask

  // exp_er per step: '.' none, 'c' code, 'v' viol, 'z' zero, 'b' code+zero
  task automatic run_seq(input string name, input string syms,
                         input string exp_do, input string exp_er);
    byte        c;
    logic [2:0] er;
    do_reset(name);
    for (int i = 0; i < syms.len(); i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      c = syms[i];
      case (c)
        "+":     {bp, bn} = 2'b10;
        "-":     {bp, bn} = 2'b01;
        "X":     {bp, bn} = 2'b11;
        default: {bp, bn} = 2'b00;
      endcase
      @(posedge clk);
      #1;
      c = exp_do[i];
      check($sformatf("%s.dout%0d", name, i + 1), {31'd0, data_out}, {31'd0, c == "1"});
      check($sformatf("%s.valid%0d", name, i + 1), {31'd0, data_valid}, {31'd0, i >= 4});
      c = exp_er[i];
      case (c)
        "c":     er = 3'b100;
        "v":     er = 3'b010;
        "z":     er = 3'b001;
        "b":     er = 3'b101;
        default: er = 3'b000;
      endcase
      check($sformatf("%s.err%0d", name, i + 1), {29'd0, code_err, viol_err, zero_err}, {29'd0, er});
    end
    $display("seq %-6s syms=%s applied", name, syms);
  endtask

  initial begin
    run_seq("alt",   "+-+-+-+-",  "00001111",  "........");
    run_seq("v000",  "+000+-+-+", "000010000", ".........");
    run_seq("b00v",  "+-00-+-+-", "000010000", ".........");
    run_seq("code",  "+-X+-+-+",  "00001101",  "..c.....");
`ifdef HDB3_ERR_CNT_EN
    check("code.cnt", {16'd0, err_cnt}, 32'd1);
`endif
    run_seq("viol",  "+0+-+-+",   "0000101",   "..v....");
    run_seq("zeros", "+00000-+-", "000010000", "....z....");
    run_seq("both",  "+000X-+-",  "00001000",  "....b...");
`ifdef HDB3_ERR_CNT_EN
    check("both.cnt", {16'd0, err_cnt}, 32'd2);
`endif
    run_seq("pre",   "+-+-+",     "00001",     ".....");
    run_seq("post",  "-+-+-",     "00001",     ".....");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
